alu_arbiter: RTL and testbench

//  Shares the single registered ALU (clk, out, a, b, shamt, funct) among NREQ requesters.

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu_arbiter_if.sv | 29 ++
 rtl/alu_arbiter_rr_arbiter.sv | 36 +++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU function codes, datapath widths and arbiter FSM states
package alu_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_SRL = 6'h02;
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester-side request/response bundle of the ALU arbiter
// master: requester side (drives req_valid and operand fields, sinks grants and responses)
// slave : arbiter side (drives req_ready and rsp_valid/rsp_data/rsp_id)
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*DATA_W-1:0]  req_a;
    logic [NREQ*DATA_W-1:0]  req_b;
    logic [NREQ*SHAMT_W-1:0] req_shamt;
    logic [NREQ*FUNCT_W-1:0] req_funct;
    logic [NREQ-1:0]         rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic [IDW-1:0]          rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_shamt, req_funct,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_shamt, req_funct,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// rtl/alu_arbiter_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
// req_i   : request vector
// ptr_i   : highest-priority requester this cycle
// grant_o : one-hot grant (zero when nothing requests)
// id_o    : binary index of the granted requester
// valid_o : a grant was made
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  id_o,
    output logic            valid_o
);
    always_comb begin : pick
        int             idx;
        logic [IDW-1:0] sel;
        idx     = 0;
        sel     = '0;
        grant_o = '0;
        id_o    = '0;
        valid_o = 1'b0;
        // Scan NREQ positions starting at ptr, wrapping modulo NREQ; first hit wins.
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            sel = idx[IDW-1:0];
            if (!valid_o && req_i[sel]) begin
                valid_o      = 1'b1;
                grant_o[sel] = 1'b1;
                id_o         = sel;
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one pipelined ALU among NREQ tagged requesters
// clk, rst_n          : clock, asynchronous active-low reset
// bus (slave)         : per-requester valid/ready and operand fields, tagged one-hot response
// drain / drain_done  : stop issuing and empty the pipeline / one-cycle pulse once empty
// busy                : any operation in flight
// alu_a/b/shamt/funct : registered operands to the external ALU
// alu_out             : ALU result, ALU_LAT cycles after alu_* change
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_arbiter_if.slave       bus,
    input  logic               drain,
    output logic               drain_done,
    output logic               busy,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SHAMT_W-1:0] alu_shamt,
    output logic [FUNCT_W-1:0] alu_funct,
    input  logic [DATA_W-1:0]  alu_out
);
    state_e               state_q;
    logic [IDW-1:0]       ptr_q;
    logic                 drain_done_q;
    logic [DATA_W-1:0]    alu_a_q;
    logic [DATA_W-1:0]    alu_b_q;
    logic [SHAMT_W-1:0]   alu_shamt_q;
    logic [FUNCT_W-1:0]   alu_funct_q;

    // In-flight tracker: stage k holds ops issued k+1 cycles ago; the last stage lines up with alu_out.
    logic [ALU_LAT:0]           fl_v_q;
    logic [ALU_LAT:0][IDW-1:0]  fl_id_q;

    logic [NREQ-1:0]      grant;
    logic [IDW-1:0]       grant_id;
    logic                 grant_vld;
    logic                 issue_en;
    logic                 hs;
    logic [IDW-1:0]       ptr_d;
    logic [DATA_W-1:0]    sel_a;
    logic [DATA_W-1:0]    sel_b;
    logic [SHAMT_W-1:0]   sel_shamt;
    logic [FUNCT_W-1:0]   sel_funct;
    logic                 last_v;
    logic [IDW-1:0]       last_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .id_o    (grant_id),
        .valid_o (grant_vld)
    );

    // Gating on rst_n keeps req_ready low while reset is held, even with requests pending.
    // A drain request blocks the grant in the very cycle it arrives.
    assign issue_en      = rst_n && !drain && (state_q == ST_IDLE || state_q == ST_RUN);
    assign bus.req_ready = issue_en ? grant : '0;
    assign hs            = issue_en && grant_vld;
    assign ptr_d         = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_shamt = '0;
        sel_funct = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_a     = bus.req_a[i*DATA_W +: DATA_W];
                sel_b     = bus.req_b[i*DATA_W +: DATA_W];
                sel_shamt = bus.req_shamt[i*SHAMT_W +: SHAMT_W];
                sel_funct = bus.req_funct[i*FUNCT_W +: FUNCT_W];
            end
        end
    end

    assign last_v  = fl_v_q[ALU_LAT];
    assign last_id = fl_id_q[ALU_LAT];

    always_comb begin
        bus.rsp_valid = '0;
        if (last_v) begin
            bus.rsp_valid[last_id] = 1'b1;
        end
    end

    assign bus.rsp_data = last_v ? alu_out : '0;
    assign bus.rsp_id   = last_v ? last_id : '0;

    assign busy       = |fl_v_q;
    assign drain_done = drain_done_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_shamt  = alu_shamt_q;
    assign alu_funct  = alu_funct_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            drain_done_q <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_shamt_q  <= '0;
            alu_funct_q  <= '0;
            fl_v_q       <= '0;
            fl_id_q      <= '0;
        end else begin
            fl_v_q  <= {fl_v_q[ALU_LAT-1:0], hs};
            fl_id_q <= {fl_id_q[ALU_LAT-1:0], grant_id};

            if (hs) begin
                alu_a_q     <= sel_a;
                alu_b_q     <= sel_b;
                alu_shamt_q <= sel_shamt;
                alu_funct_q <= sel_funct;
                ptr_q       <= ptr_d;
            end

            drain_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (drain) begin
                        state_q <= ST_DRAIN;
                    end else if (|bus.req_valid) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (drain) begin
                        state_q <= ST_DRAIN;
                    end else if (!(|bus.req_valid) && !busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!busy) begin
                        state_q      <= ST_DONE;
                        drain_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!drain) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a registered behavioural ALU
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int ALU_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        drain = 1'b0;
    logic        drain_done;
    logic        busy;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_shamt;
    logic [5:0]  alu_funct;

    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .drain      (drain),
        .drain_done (drain_done),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_shamt  (alu_shamt),
        .alu_funct  (alu_funct),
        .alu_out    (alu_out)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [5:0] fn);
        case (fn)
            FN_SLL:  return a << sh;
            FN_SRL:  return a >> sh;
            FN_ADD:  return a + b;
            FN_SUB:  return a - b;
            default: return 32'h0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_out <= '0;
        else        alu_out <= alu_ref(alu_a, alu_b, alu_shamt, alu_funct);
    end

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    logic [NREQ-1:0] vld_t;
    logic [31:0]     a_t [NREQ];
    logic [31:0]     b_t [NREQ];
    logic [4:0]      sh_t[NREQ];
    logic [5:0]      fn_t[NREQ];

    exp_t sb[$];
    int   glog[$];
    int   rlog[$];
    int   ptr_m, mstate, done_first, cyc;
    int   checks, failures, issued, rsp_seen, dd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic newf(input int i);
        a_t[i]  = $urandom;
        b_t[i]  = $urandom;
        sh_t[i] = 5'($urandom);
        case ($urandom_range(0, 3))
            0:       fn_t[i] = FN_SLL;
            1:       fn_t[i] = FN_SRL;
            2:       fn_t[i] = FN_ADD;
            default: fn_t[i] = FN_SUB;
        endcase
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[32*i +: 32]    = a_t[i];
            bus.req_b[32*i +: 32]    = b_t[i];
            bus.req_shamt[5*i +: 5]  = sh_t[i];
            bus.req_funct[6*i +: 6]  = fn_t[i];
        end
        bus.req_valid = vld_t;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"},  32'(bus.req_ready), 32'h0);
        chk({tag, "_rspv"},   32'(bus.rsp_valid), 32'h0);
        chk({tag, "_rspd"},   bus.rsp_data,       32'h0);
        chk({tag, "_rspid"},  32'(bus.rsp_id),    32'h0);
        chk({tag, "_ddone"},  32'(drain_done),    32'h0);
        chk({tag, "_busy"},   32'(busy),          32'h0);
        chk({tag, "_alua"},   alu_a,              32'h0);
        chk({tag, "_alub"},   alu_b,              32'h0);
        chk({tag, "_alush"},  32'(alu_shamt),     32'h0);
        chk({tag, "_alufn"},  32'(alu_funct),     32'h0);
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step();
        logic [NREQ-1:0] er;
        logic [NREQ-1:0] rv;
        int              eg;
        int              regen;
        logic            busy_exp;
        exp_t            e;
        drive();
        #1;
        eg = -1;
        if (rst_n && mstate == 0 && !drain) begin
            for (int k = 0; k < NREQ; k++) begin
                int j = (ptr_m + k) % NREQ;
                if (eg < 0 && vld_t[j]) eg = j;
            end
        end
        er = '0;
        if (eg >= 0) er[eg] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(er));

        busy_exp = (sb.size() != 0);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e  = sb.pop_front();
            rv = '0;
            rv[e.id] = 1'b1;
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
            chk("rsp_id",    32'(bus.rsp_id),    32'(e.id));
            chk("rsp_data",  bus.rsp_data,       e.data);
        end else begin
            chk("rsp_idle", 32'(bus.rsp_valid), 32'h0);
        end
        chk("busy",       32'(busy),       32'(busy_exp));
        chk("drain_done", 32'(drain_done), 32'(mstate == 2 && done_first == 1));
        if (bus.rsp_valid != '0) begin
            rsp_seen++;
            rlog.push_back(int'(bus.rsp_id));
        end
        if (drain_done) dd_seen++;

        regen = -1;
        if (eg >= 0) begin
            glog.push_back(eg);
            e.due  = cyc + 1 + ALU_LAT;
            e.id   = eg;
            e.data = alu_ref(a_t[eg], b_t[eg], sh_t[eg], fn_t[eg]);
            sb.push_back(e);
            ptr_m = (eg + 1) % NREQ;
            issued++;
            regen = eg;
        end
        case (mstate)
            0: if (drain) mstate = 1;
            1: if (!busy_exp) begin mstate = 2; done_first = 1; end
            default: begin done_first = 0; if (!drain) mstate = 0; end
        endcase
        cyc++;
        @(posedge clk);
        #1;
        if (regen >= 0) newf(regen);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, gs;
        checks = 0; failures = 0; issued = 0; rsp_seen = 0; dd_seen = 0;
        ptr_m = 0; mstate = 0; done_first = 0; cyc = 0;
        vld_t = '0;
        for (int i = 0; i < NREQ; i++) newf(i);
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst0");
        rst_n = 1'b1;
        step();
        step();

        // Single ops: SLL then SRL on requester 0
        a_t[0] = 32'h1000; b_t[0] = 32'd4; sh_t[0] = 5'd1; fn_t[0] = FN_SLL;
        vld_t = 4'b0001;
        step();
        vld_t = '0;
        step();
        #1;
        chk("sll_rspv", 32'(bus.rsp_valid), 32'h1);
        chk("sll_data", bus.rsp_data, 32'h2000);
        step();
        a_t[0] = 32'h1000; b_t[0] = 32'd4; sh_t[0] = 5'd1; fn_t[0] = FN_SRL;
        vld_t = 4'b0001;
        step();
        vld_t = '0;
        step();
        #1;
        chk("srl_rspv", 32'(bus.rsp_valid), 32'h1);
        chk("srl_data", bus.rsp_data, 32'h0800);
        step();

        // Fairness: bring ptr back to 0, then all four valid for 8 cycles
        vld_t = 4'b1000;
        step();
        vld_t = '0;
        repeat (3) step();
        glog.delete();
        rlog.delete();
        vld_t = '1;
        repeat (8) step();
        vld_t = '0;
        repeat (3) step();
        chk("fair_count", 32'(glog.size()), 32'd8);
        chk("fair_rcount", 32'(rlog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < glog.size()) chk("fair_grant", 32'(glog[i]), 32'(i % 4));
            if (i < rlog.size()) chk("fair_rspid", 32'(rlog[i]), 32'(i % 4));
        end

        // Wrap/skip: ptr to 3, then only requesters 1 and 3
        vld_t = 4'b0100;
        step();
        glog.delete();
        vld_t = 4'b1010;
        repeat (3) step();
        vld_t = '0;
        repeat (3) step();
        chk("wrap_count", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            chk("wrap_g0", 32'(glog[0]), 32'd3);
            chk("wrap_g1", 32'(glog[1]), 32'd1);
            chk("wrap_g2", 32'(glog[2]), 32'd3);
        end

        // Drain with two ops in flight
        vld_t = '1;
        step();
        step();
        dd_seen = 0;
        drain = 1'b1;
        drive();
        #1;
        chk("drain_ready0", 32'(bus.req_ready), 32'h0);
        chk("drain_busy",   32'(busy), 32'h1);
        repeat (6) step();
        chk("drain_idle_busy", 32'(busy), 32'h0);
        drain = 1'b0;
        gs = glog.size();
        repeat (3) step();
        vld_t = '0;
        repeat (3) step();
        chk("drain_pulses", 32'(dd_seen), 32'd1);
        chk("drain_resume", 32'(glog.size() > gs), 32'h1);

        // Random back-to-back traffic
        n0 = issued;
        for (int t = 0; t < 300 && (issued - n0) < 16; t++) begin
            vld_t = NREQ'($urandom);
            step();
        end
        vld_t = '0;
        repeat (4) step();
        chk("rand_issued", 32'(issued - n0), 32'd16);
        chk("rand_rsp_all", 32'(rsp_seen), 32'(issued));
        chk("rand_sb_empty", 32'(sb.size()), 32'h0);

        // Reset in the middle of traffic
        for (int i = 0; i < NREQ; i++) newf(i);
        vld_t = '1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        sb.delete();
        ptr_m = 0; mstate = 0; done_first = 0;
        vld_t = '0;
        drive();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        glog.delete();
        vld_t = '1;
        step();
        vld_t = '0;
        repeat (4) step();
        chk("rst_first_grant", 32'((glog.size() > 0) ? glog[0] : -1), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
